// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
//   port_id_t               : requester index (0 = CPU core, 1 = IO/DMA loader)
//   arb_state_t             : arbiter FSM states
//   rd_entry_t              : one slot of the read-return pipe
package ram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  typedef logic port_id_t;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_entry_t;

endpackage

// File: rtl/ram_arb_rd_pipe.sv
// Read-return pipe: delays a {valid, port} tag by RD_LAT cycles so read data
// coming back from the RAM can be steered to the port that issued the read.
//   clk_i    : system clock
//   rst_i    : asynchronous active-high reset, flushes all pending reads
//   push_i   : tag entered on the grant cycle (valid only for granted reads)
//   rvalid_o : one-hot per-port read-valid, RD_LAT cycles after push
module ram_arb_rd_pipe
  import ram_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  rd_entry_t push_i,
  output logic [1:0] rvalid_o
);

  rd_entry_t r_pipe [RD_LAT];
  rd_entry_t w_tail;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      r_pipe[0] <= push_i;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_comb begin
    w_tail   = r_pipe[RD_LAT-1];
    rvalid_o = {w_tail.valid & w_tail.port, w_tail.valid & ~w_tail.port};
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port byte RAM.
// Round-robin between port 0 (CPU) and port 1 (IO/DMA), optional per-port lock
// for atomic multi-byte sequences with a watchdog, and tagged read return.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   req_i/we_i/lock_i       : per-port request, write enable, keep-ownership
//   addr{0,1}_i/wdata{0,1}_i: per-port address and write data
//   gnt_o                   : one-hot grant, combinational
//   rvalid_o/rdata_o        : read return, rdata_o is zero unless rvalid_o
//   lock_err_o              : sticky per-port lock-timeout flag
//   ram_address_o/ram_data_o/ram_we_o/ram_data_i : RAM side
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [1:0]        lock_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        gnt_o,
  output logic [1:0]        rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        lock_err_o,
  output logic [ADDR_W-1:0] ram_address_o,
  output logic [DATA_W-1:0] ram_data_o,
  output logic              ram_we_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  arb_state_t r_state, w_state_nxt;
  port_id_t   r_owner, w_owner_nxt;
  port_id_t   r_last,  w_last_nxt;
  logic [7:0] r_cnt,   w_cnt_nxt;
  logic [1:0] r_lock_err, w_lock_err_nxt;

  logic [1:0] w_gnt;
  port_id_t   w_sel;
  logic       w_any;
  logic       w_timeout;
  rd_entry_t  w_push;

  assign w_timeout = (r_cnt == 8'(LOCK_MAX - 1));

  // Grant pick. Held at zero during reset so the RAM side goes quiet at once.
  always_comb begin
    w_gnt = '0;
    w_sel = 1'b0;
    if (!rst_i) begin
      unique case (r_state)
        ARB: begin
          if (req_i[0] && req_i[1]) begin
            w_sel        = ~r_last;
            w_gnt[w_sel] = 1'b1;
          end else if (req_i[0]) begin
            w_sel    = 1'b0;
            w_gnt[0] = 1'b1;
          end else if (req_i[1]) begin
            w_sel    = 1'b1;
            w_gnt[1] = 1'b1;
          end
        end
        LOCKED: begin
          // Non-owner is held off even while the owner is idle.
          if (req_i[r_owner]) begin
            w_sel          = r_owner;
            w_gnt[r_owner] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_any = |w_gnt;
  assign gnt_o = w_gnt;

  always_comb begin
    ram_we_o      = 1'b0;
    ram_address_o = '0;
    ram_data_o    = '0;
    if (w_any) begin
      ram_we_o      = we_i[w_sel];
      ram_address_o = w_sel ? addr1_i : addr0_i;
      ram_data_o    = w_sel ? wdata1_i : wdata0_i;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_cnt_nxt      = r_cnt;
    w_lock_err_nxt = r_lock_err;
    if (w_any) begin
      w_last_nxt = w_sel;
    end
    unique case (r_state)
      ARB: begin
        if (w_any && lock_i[w_sel]) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_sel;
          w_cnt_nxt   = '0;
        end
      end
      LOCKED: begin
        w_cnt_nxt = r_cnt + 8'd1;
        // Only the owner can be granted here, so a dropped lock_i covers both
        // "granted without lock" and "idle without lock" exits.
        if (w_timeout || !lock_i[r_owner]) begin
          w_state_nxt = ARB;
          w_cnt_nxt   = '0;
          w_last_nxt  = r_owner;
          if (w_timeout) begin
            w_lock_err_nxt[r_owner] = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ARB;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ARB;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_lock_err <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lock_err <= w_lock_err_nxt;
    end
  end

  assign lock_err_o = r_lock_err;

  always_comb begin
    w_push       = '0;
    w_push.valid = w_any & ~we_i[w_sel];
    w_push.port  = w_sel;
  end

  ram_arb_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_i   (w_push),
    .rvalid_o (rvalid_o)
  );

  assign rdata_o = (|rvalid_o) ? ram_data_i : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, we, lock;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic [1:0]  gnt, rvalid, lock_err;
  logic [7:0]  rdata;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  logic [7:0]  mem [0:65535];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // RAM model: 1-cycle registered read, write on edge.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  ram_arbiter #(
    .ADDR_W   (16),
    .DATA_W   (8),
    .RD_LAT   (1),
    .LOCK_MAX (8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .req_i         (req),
    .we_i          (we),
    .lock_i        (lock),
    .addr0_i       (addr0),
    .addr1_i       (addr1),
    .wdata0_i      (wdata0),
    .wdata1_i      (wdata1),
    .gnt_o         (gnt),
    .rvalid_o      (rvalid),
    .rdata_o       (rdata),
    .lock_err_o    (lock_err),
    .ram_address_o (ram_addr),
    .ram_data_o    (ram_wdata),
    .ram_we_o      (ram_we),
    .ram_data_i    (ram_rdata)
  );

  task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    req = r; we = w; lock = l; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(2'b11, 2'b01, 2'b11, 16'hAAAA, 16'h5555, 8'h12, 8'h34);
    #3;
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt got %b want 00", gnt); end
    n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b want 00", rvalid); end
    n_cmp++; if (lock_err !== 2'b00) begin n_fail++; $display("FAIL reset_lock_err got %b want 00", lock_err); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we got %b want 0", ram_we); end
    n_cmp++; if (ram_addr !== 16'h0) begin n_fail++; $display("FAIL reset_ram_addr got %h want 0000", ram_addr); end
    n_cmp++; if (ram_wdata !== 8'h0) begin n_fail++; $display("FAIL reset_ram_data got %h want 00", ram_wdata); end
    n_cmp++; if (rdata !== 8'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 00", rdata); end
    do_reset();
  endtask

  task automatic test_single_read();
    poke(16'h1234, 8'hA5);
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 16'h1234, 16'h0, 8'h0, 8'h0);
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL sr_gnt got %b want 01", gnt); end
    n_cmp++; if (ram_addr !== 16'h1234) begin n_fail++; $display("FAIL sr_addr got %h want 1234", ram_addr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL sr_we got %b want 0", ram_we); end
    @(negedge clk);
    n_cmp++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL sr_rvalid got %b want 01", rvalid); end
    n_cmp++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL sr_rdata got %h want a5", rdata); end
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    #1;
    n_cmp++; if (ram_addr !== 16'h0) begin n_fail++; $display("FAIL sr_idle_addr got %h want 0000", ram_addr); end
    @(negedge clk);
    n_cmp++; if (rdata !== 8'h0) begin n_fail++; $display("FAIL sr_idle_rdata got %h want 00", rdata); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp [4];
    logic [1:0] prev;
    exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b10;
    poke(16'h0010, 8'h11);
    poke(16'h0020, 8'h22);
    do_reset();
    prev = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(2'b11, 2'b00, 2'b00, 16'h0010, 16'h0020, 8'h0, 8'h0);
      #1;
      n_cmp++;
      if (gnt !== exp[i]) begin n_fail++; $display("FAIL b2b_gnt[%0d] got %b want %b", i, gnt, exp[i]); end
      n_cmp++;
      if (rvalid !== prev) begin n_fail++; $display("FAIL b2b_rvalid[%0d] got %b want %b", i, rvalid, prev); end
      if (prev != 2'b00) begin
        n_cmp++;
        if (rdata !== ((prev == 2'b01) ? 8'h11 : 8'h22)) begin
          n_fail++; $display("FAIL b2b_rdata[%0d] got %h", i, rdata);
        end
      end
      prev = exp[i];
    end
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    #1;
    n_cmp++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL b2b_last_rvalid got %b want 10", rvalid); end
    n_cmp++; if (rdata !== 8'h22) begin n_fail++; $display("FAIL b2b_last_rdata got %h want 22", rdata); end
  endtask

  task automatic test_lock_sequence();
    do_reset();
    // Give port 0 one grant so port 1 wins the following conflict.
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 16'h0030, 16'h0, 8'h0, 8'h0);
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL lk_pre_gnt got %b want 01", gnt); end
    @(negedge clk);
    drive(2'b11, 2'b10, 2'b10, 16'h0030, 16'h00FF, 8'h0, 8'h7E);
    #1;
    n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_wr_gnt got %b want 10", gnt); end
    n_cmp++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL lk_wr_we got %b want 1", ram_we); end
    n_cmp++; if (ram_addr !== 16'h00FF) begin n_fail++; $display("FAIL lk_wr_addr got %h want 00ff", ram_addr); end
    n_cmp++; if (ram_wdata !== 8'h7E) begin n_fail++; $display("FAIL lk_wr_data got %h want 7e", ram_wdata); end
    @(negedge clk);
    drive(2'b11, 2'b00, 2'b00, 16'h0030, 16'h00FF, 8'h0, 8'h0);
    #1;
    n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_rd_gnt got %b want 10", gnt); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL lk_rd_we got %b want 0", ram_we); end
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b00, 16'h0030, 16'h0, 8'h0, 8'h0);
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL lk_after_gnt got %b want 01", gnt); end
    n_cmp++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL lk_rvalid got %b want 10", rvalid); end
    n_cmp++; if (rdata !== 8'h7E) begin n_fail++; $display("FAIL lk_rdata got %h want 7e", rdata); end
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    #1;
    n_cmp++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL lk_p0_rvalid got %b want 01", rvalid); end
  endtask

  task automatic test_lock_timeout();
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b01, 16'h0040, 16'h0, 8'h0, 8'h0);
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL to_entry_gnt got %b want 01", gnt); end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      drive(2'b10, 2'b00, 2'b01, 16'h0040, 16'h0050, 8'h0, 8'h0);
      #1;
      n_cmp++;
      if (gnt !== 2'b00) begin n_fail++; $display("FAIL to_block_gnt[%0d] got %b want 00", i, gnt); end
      n_cmp++;
      if (lock_err !== 2'b00) begin n_fail++; $display("FAIL to_err_early[%0d] got %b want 00", i, lock_err); end
    end
    @(negedge clk);
    #1;
    n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL to_release_gnt got %b want 10", gnt); end
    n_cmp++; if (lock_err !== 2'b01) begin n_fail++; $display("FAIL to_err got %b want 01", lock_err); end
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    @(negedge clk);
    #1;
    n_cmp++; if (lock_err !== 2'b01) begin n_fail++; $display("FAIL to_err_sticky got %b want 01", lock_err); end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b00, 2'b01, 16'h0060, 16'h0, 8'h0, 8'h0);
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rm_entry_gnt got %b want 01", gnt); end
    @(negedge clk);
    drive(2'b11, 2'b00, 2'b01, 16'h0060, 16'h0070, 8'h0, 8'h0);
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rm_owner_gnt got %b want 01", gnt); end
    n_cmp++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL rm_inflight got %b want 01", rvalid); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rm_gnt got %b want 00", gnt); end
    n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rm_rvalid got %b want 00", rvalid); end
    n_cmp++; if (rdata !== 8'h0) begin n_fail++; $display("FAIL rm_rdata got %h want 00", rdata); end
    n_cmp++; if (ram_addr !== 16'h0) begin n_fail++; $display("FAIL rm_addr got %h want 0000", ram_addr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rm_we got %b want 0", ram_we); end
    @(negedge clk);
    n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rm_hold_rvalid got %b want 00", rvalid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rm_first_gnt got %b want 01", gnt); end
    n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rm_spurious got %b want 00", rvalid); end
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
    #1;
    n_cmp++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL rm_post_rvalid got %b want 01", rvalid); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_lock_sequence();
    test_lock_timeout();
    test_reset_mid_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
